// File: rtl/exibe_sequencia.sv
// exibe_sequencia: plays back the stored move sequence of the memory game.
// On a start request it reads the jogadas memory from address 0 up to the
// captured limit and lights each move on the LEDs for T_ON cycles, followed
// by T_OFF dark cycles, then pulses pronto for one cycle.
//
// Ports:
//   clock            single clock, rising edge
//   reset            synchronous, active-high reset
//   iniciar_exibicao start request, honoured only while idle
//   limite           index of the last move to show, captured at start
//   dado_mem         asynchronous-read memory data for endereco
//   endereco         memory read address
//   leds             LED drive (zero outside the lit phase)
//   exibindo         high while a playback is in progress
//   pronto           one-cycle completion pulse
//   db_estado        current state code, for debug
module exibe_sequencia #(
  parameter int unsigned T_ON   = 500,
  parameter int unsigned T_OFF  = 250,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar_exibicao,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] dado_mem,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              exibindo,
  output logic              pronto,
  output logic [2:0]        db_estado
);

  localparam int unsigned T_MAX   = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int unsigned TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(T_ON - 1);
  localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(T_OFF - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACENDE  = 3'd2,
    APAGA   = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t             estado, estado_next;
  logic [ADDR_W-1:0]   lim_r, lim_next;
  logic [ADDR_W-1:0]   end_r, end_next;
  logic [DATA_W-1:0]   dado_r, dado_next;
  logic [TIMER_W-1:0]  timer, timer_next;

  logic [DATA_W-1:0]   leds_next;
  logic                exibindo_next;
  logic                pronto_next;
  logic [2:0]          db_estado_next;

  // Next-state, datapath and output decode. Outputs are computed from the
  // next state so that the registered outputs line up with the state.
  always_comb begin
    estado_next = estado;
    lim_next    = lim_r;
    end_next    = end_r;
    dado_next   = dado_r;
    timer_next  = timer;

    case (estado)
      OCIOSO: begin
        if (iniciar_exibicao) begin
          estado_next = CARREGA;
          lim_next    = limite;
          end_next    = '0;
          timer_next  = '0;
        end
      end
      CARREGA: begin
        dado_next   = dado_mem;
        timer_next  = '0;
        estado_next = ACENDE;
      end
      ACENDE: begin
        if (timer == ON_LAST) begin
          timer_next  = '0;
          estado_next = APAGA;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      APAGA: begin
        if (timer == OFF_LAST) begin
          timer_next  = '0;
          // The limit check ends playback before end_r can wrap.
          estado_next = (end_r == lim_r) ? FIM : PROXIMO;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      PROXIMO: begin
        end_next    = end_r + ADDR_W'(1);
        estado_next = CARREGA;
      end
      FIM: begin
        estado_next = OCIOSO;
      end
      default: begin
        estado_next = OCIOSO;
      end
    endcase

    leds_next      = (estado_next == ACENDE) ? dado_next : '0;
    exibindo_next  = (estado_next != OCIOSO);
    pronto_next    = (estado_next == FIM);
    db_estado_next = 3'(estado_next);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= OCIOSO;
      lim_r     <= '0;
      end_r     <= '0;
      dado_r    <= '0;
      timer     <= '0;
      leds      <= '0;
      exibindo  <= 1'b0;
      pronto    <= 1'b0;
      db_estado <= 3'd0;
    end else begin
      estado    <= estado_next;
      lim_r     <= lim_next;
      end_r     <= end_next;
      dado_r    <= dado_next;
      timer     <= timer_next;
      leds      <= leds_next;
      exibindo  <= exibindo_next;
      pronto    <= pronto_next;
      db_estado <= db_estado_next;
    end
  end

  assign endereco = end_r;

endmodule

// File: tb/tb_exibe_sequencia.sv
// tb_exibe_sequencia: self-checking bench for exibe_sequencia with T_ON=3,
// T_OFF=2. A cycle-count model derives every output from the playback timing
// rules; directed runs pin the model with literal values, then randomized
// runs (random memory, limits, start glitches and resets) are compared
// against the model every cycle.
module tb_exibe_sequencia;

  localparam int unsigned T_ON   = 3;
  localparam int unsigned T_OFF  = 2;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 4;
  localparam int PER = int'(T_ON) + int'(T_OFF) + 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              iniciar_exibicao;
  logic [ADDR_W-1:0] limite;
  logic [DATA_W-1:0] dado_mem;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] leds;
  logic              exibindo;
  logic              pronto;
  logic [2:0]        db_estado;

  logic [DATA_W-1:0] mem [16];

  exibe_sequencia #(
    .T_ON  (T_ON),
    .T_OFF (T_OFF),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .iniciar_exibicao(iniciar_exibicao),
    .limite          (limite),
    .dado_mem        (dado_mem),
    .endereco        (endereco),
    .leds            (leds),
    .exibindo        (exibindo),
    .pronto          (pronto),
    .db_estado       (db_estado)
  );

  assign dado_mem = mem[endereco];

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: cycle index since the accepted start, move count, last address.
  bit m_idle     = 1'b1;
  int m_c        = 0;
  int m_n        = 1;
  int m_end_last = 0;
  bit chk_en     = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_idle     = 1'b1;
      m_end_last = 0;
    end else if (m_idle) begin
      if (iniciar_exibicao) begin
        m_idle = 1'b0;
        m_c    = 1;
        m_n    = int'(limite) + 1;
      end
    end else begin
      m_c++;
      if (m_c > m_n * PER) begin
        m_idle     = 1'b1;
        m_end_last = m_n - 1;
      end
    end
  end

  // Expected outputs from the period arithmetic: each move occupies PER
  // cycles (load, T_ON lit, T_OFF dark, advance/finish).
  function automatic void model_out(output int e_db, output int e_leds, output int e_exib,
                                    output int e_pronto, output int e_end);
    int k, off;
    e_db = 0; e_leds = 0; e_exib = 0; e_pronto = 0; e_end = m_end_last;
    if (!m_idle) begin
      k      = (m_c - 1) / PER;
      off    = (m_c - 1) % PER;
      e_end  = k;
      e_exib = 1;
      if (off == 0) e_db = 1;
      else if (off <= int'(T_ON)) begin
        e_db   = 2;
        e_leds = int'(mem[k]);
      end else if (off <= int'(T_ON) + int'(T_OFF)) e_db = 3;
      else if (k == m_n - 1) begin
        e_db     = 5;
        e_pronto = 1;
      end else e_db = 4;
    end
  endfunction

  always @(negedge clock) begin
    int e_db, e_leds, e_exib, e_pronto, e_end;
    if (chk_en) begin
      model_out(e_db, e_leds, e_exib, e_pronto, e_end);
      check("db_estado", 32'(db_estado), 32'(e_db));
      check("leds",      32'(leds),      32'(e_leds));
      check("exibindo",  32'(exibindo),  32'(e_exib));
      check("pronto",    32'(pronto),    32'(e_pronto));
      check("endereco",  32'(endereco),  32'(e_end));
    end
  end

  // Advance to just after the falling edge of the next cycle.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  int db_seq [8] = '{1, 2, 2, 2, 3, 3, 5, 0};

  initial begin
    int lit, max_end, npronto, budget;
    reset = 1'b1;
    iniciar_exibicao = 1'b0;
    limite = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    tick();
    tick();
    chk_en = 1'b1;
    check("reset_db", 32'(db_estado), 32'd0);
    check("reset_leds", 32'(leds), 32'd0);
    check("reset_exib", 32'(exibindo), 32'd0);
    reset = 1'b0;
    tick();

    // Single move, limite = 0.
    mem[0] = 4'b0010;
    limite = 4'd0;
    iniciar_exibicao = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 1) iniciar_exibicao = 1'b0;
      check("t1_db_seq", 32'(db_estado), 32'(db_seq[n-1]));
      if (n >= 2 && n <= 4) check("t1_leds_on", 32'(leds), 32'h2);
      if (n == 7) check("t1_pronto", 32'(pronto), 32'd1);
    end

    // Three moves, limite = 2.
    mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000;
    limite = 4'd2;
    iniciar_exibicao = 1'b1;
    for (int n = 1; n <= 23; n++) begin
      tick();
      if (n == 1) iniciar_exibicao = 1'b0;
      if (n == 3)  begin check("t2_leds0", 32'(leds), 32'h1); check("t2_end0", 32'(endereco), 32'd0); end
      if (n == 10) begin check("t2_leds1", 32'(leds), 32'h4); check("t2_end1", 32'(endereco), 32'd1); end
      if (n == 17) begin check("t2_leds2", 32'(leds), 32'h8); check("t2_end2", 32'(endereco), 32'd2); end
      if (n == 21) check("t2_pronto", 32'(pronto), 32'd1);
    end

    // Start held high, limite changed mid-run.
    limite = 4'd1;
    iniciar_exibicao = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      tick();
      if (n == 4) limite = 4'd3;
      if (n == 13) check("t3_no_early_pronto", 32'(pronto), 32'd0);
      if (n == 14) begin
        check("t3_pronto", 32'(pronto), 32'd1);
        iniciar_exibicao = 1'b0;
      end
      if (n == 16) check("t3_idle", 32'(db_estado), 32'd0);
    end

    // Reset while a move is lit.
    mem[0] = 4'b0010;
    limite = 4'd0;
    iniciar_exibicao = 1'b1;
    tick(); iniciar_exibicao = 1'b0;
    tick();
    tick();
    check("t4_lit", 32'(leds), 32'h2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_leds", 32'(leds), 32'd0);
    check("t4_end", 32'(endereco), 32'd0);
    check("t4_exib", 32'(exibindo), 32'd0);
    check("t4_db", 32'(db_estado), 32'd0);
    npronto = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (pronto) npronto++;
    end
    check("t4_no_pronto", 32'(npronto), 32'd0);

    // Full memory, limite = 15.
    for (int i = 0; i < 16; i++) mem[i] = 4'b0001;
    limite = 4'd15;
    iniciar_exibicao = 1'b1;
    lit = 0;
    max_end = 0;
    for (int n = 1; n <= 113; n++) begin
      tick();
      if (n == 1) iniciar_exibicao = 1'b0;
      if (leds != '0) lit++;
      if (int'(endereco) > max_end) max_end = int'(endereco);
      if (n == 112) check("t5_pronto", 32'(pronto), 32'd1);
    end
    check("t5_lit_cycles", 32'(lit), 32'd48);
    check("t5_max_end", 32'(max_end), 32'd15);
    check("t5_no_wrap", 32'(endereco), 32'd15);

    // Randomized runs against the model.
    for (int run = 0; run < 60; run++) begin
      for (int i = 0; i < 16; i++)
        mem[i] = ($urandom_range(7) == 0) ? 4'b0000 : 4'(4'b0001 << $urandom_range(3));
      limite = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(3));
      iniciar_exibicao = 1'b1;
      tick();
      iniciar_exibicao = 1'($urandom_range(1));
      budget = 0;
      while (!m_idle && budget < 300) begin
        budget++;
        if ($urandom_range(3) == 0) iniciar_exibicao = ~iniciar_exibicao;
        if ($urandom_range(5) == 0) limite = 4'($urandom_range(15));
        reset = ($urandom_range(99) == 0);
        tick();
      end
      reset = 1'b0;
      iniciar_exibicao = 1'b0;
      if (budget >= 300) check("rand_timeout", 32'd0, 32'd1);
      tick();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
